uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  8N1 UART receiver; the downstream counterpart of the UART transmitter on the serial line.
//  - Synchronises the asynchronous rx line and samples each bit at its centre.
//  - Delivers each received byte on a valid/ready interface to the peripheral register/FIFO side.
//  - Flags framing errors and overruns as one-cycle pulses.
// PARAMETERS
//  CLK_FREQ  100_000_000  clock frequency in Hz
//  BAUD      115200       baud rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide), must be >= 4
// PORTS
//  clk_i        in   1  clock, single domain
//  rst_i        in   1  asynchronous, active-high reset
//  rx_i         in   1  UART RX line, asynchronous, idle high
//  data_o       out  8  received byte, stable while valid_o=1
//  valid_o      out  1  byte available; held until accepted
//  ready_i      in   1  consumer accepts; transfer when valid_o & ready_i
//  frame_err_o  out  1  1-cycle pulse: stop bit sampled low
//  overrun_o    out  1  1-cycle pulse: new byte dropped because the holding reg was full
// BEHAVIOUR
//  - Reset (async, rst_i=1):
//    - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0.
//    - Both synchroniser flops =1; state=IDLE; counter=0; bit index=0.
//  - Sync: rx_i passes through 2 flops -> rx_s. All decisions use rx_s only (2-cycle input delay).
//  - Counter width: $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2.
//  - FSM:
//    - IDLE: rx_s==0 -> START, counter=0.
//    - START: count to HALF-1, then sample rx_s.
//      - 0 -> DATA, counter=0, idx=0.
//      - 1 -> glitch/false start -> IDLE; no flag raised.
//    - DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift reg LSB-first, counter=0, idx++.
//      After idx 7 is sampled -> STOP.
//    - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
//      - 1 -> deliver byte, -> IDLE.
//      - 0 -> frame_err_o pulse, byte discarded, -> BREAK.
//    - BREAK: wait for rx_s==1 -> IDLE. A break condition yields exactly one frame_err pulse.
//  - Deliver (the cycle after the stop sample):
//    - valid_o=0, or valid_o & ready_i in the same cycle -> data_o<=byte, valid_o<=1.
//    - otherwise -> overrun_o pulse; old data_o/valid_o kept; new byte lost.
//  - Accept: valid_o & ready_i with no simultaneous deliver -> valid_o<=0 next cycle. data_o is unchanged.
//  - Latency: valid_o rises 1 clk after the stop-bit sample, i.e. ~9.5 bit times + 3 clks after the start edge.
//  - Line noise inside a frame is not filtered; single-sample-per-bit decision.
//  - rst_i mid-frame: immediate return to reset state; the partial byte is discarded.
//    Reception resumes at the next falling edge after reset deasserts.
//  - Back-to-back frames: IDLE is re-entered at the stop-bit centre, so a start edge half a bit later is caught.
// STRUCTURE
//  - uart_pkg (shared with uart_tx):
//    - typedef enum uart_rx_state_t {IDLE,START,DATA,STOP,BREAK}.
//    - function clks_per_bit(clk_freq, baud).
//    - localparam UART_DATA_BITS=8.
//  - Sub-module uart_sync_2ff: 2-flop synchroniser, reset value parameterised (RST_VAL=1 here).
//  - Elaboration assertion: CLKS_PER_BIT >= 4.
// TESTING (CLK_FREQ=1_000_000, BAUD=100_000 -> 10 clks/bit, ready_i=1 unless stated)
//  - Single byte 0xA5 driven 8N1 -> valid_o for 1 clk with data_o=0xA5; no error pulses.
//  - rx_i low for 3 clks then high -> no valid_o, no frame_err_o; FSM back in IDLE.
//  - Frame 0x3C with stop bit low, rx then low for 30 clks, then high -> exactly one frame_err_o, no valid_o.
//    Next frame 0x12 -> data_o=0x12.
//  - ready_i=0; send 0x11 then 0x22 -> valid_o=1 with data_o=0x11, one overrun_o pulse, data_o stays 0x11.
//    Raise ready_i -> valid_o drops.
//  - Assert rst_i for 2 clks at DATA bit 3 of 0xFF -> outputs zero, no valid_o for that frame.
//    Next frame 0x5A -> data_o=0x5A.
//  - Loopback from uart_tx, rst_ni=~rst_i: 256 bytes 0x00..0xFF back-to-back -> all received in order, zero errors.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud helper
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// rtl/uart_sync_2ff.sv - two-flop synchroniser with parameterised reset value
module uart_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready byte output and error pulses
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      frame_err_o,
    output logic                      overrun_o
);

    localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW   = $clog2(CPB);
    localparam int HALF = CPB / 2;
    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);

    generate
        if (CPB < 4) begin : g_cpb_check
            $error("uart_rx: CLKS_PER_BIT must be >= 4");
        end
    endgenerate

    logic rx_s;

    uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    uart_rx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      deliver;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit that is high again at its centre was only a glitch.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register: a new byte may replace the old one only in the cycle it is accepted.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (deliver) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 10;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i  = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;

    int n_cmp = 0;
    int n_bad = 0;

    int         vcyc = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         rx_n = 0;
    logic [7:0] rx_mem [0:1023];

    uart_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (valid_o) vcyc <= vcyc + 1;
            if (valid_o && ready_i) begin
                rx_mem[rx_n[9:0]] <= data_o;
                rx_n <= rx_n + 1;
            end
            if (frame_err_o) fe_cnt <= fe_cnt + 1;
            if (overrun_o) ov_cnt <= ov_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic send_bit(input logic v);
        rx_i = v;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        chk("reset data_o", int'(data_o), 0);
        chk("reset valid_o", int'(valid_o), 0);
        chk("reset frame_err_o", int'(frame_err_o), 0);
        chk("reset overrun_o", int'(overrun_o), 0);
        chk("reset state", int'(dut.state_q), int'(IDLE));
        rst_i = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_single();
        int v0, f0, o0, n0;
        v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt; n0 = rx_n;
        send_frame(8'hA5, 1'b1);
        repeat (20) tick();
        chk("single valid cycles", vcyc - v0, 1);
        chk("single count", rx_n - n0, 1);
        chk("single data", int'(rx_mem[n0]), 8'hA5);
        chk("single frame_err", fe_cnt - f0, 0);
        chk("single overrun", ov_cnt - o0, 0);
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = vcyc; f0 = fe_cnt;
        rx_i = 1'b0;
        repeat (3) tick();
        rx_i = 1'b1;
        repeat (30) tick();
        chk("glitch valid", vcyc - v0, 0);
        chk("glitch frame_err", fe_cnt - f0, 0);
        chk("glitch state", int'(dut.state_q), int'(IDLE));
    endtask

    task automatic test_frame_err();
        int v0, f0, n0;
        v0 = vcyc; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        rx_i = 1'b0;
        repeat (30) tick();
        rx_i = 1'b1;
        repeat (20) tick();
        chk("break frame_err pulses", fe_cnt - f0, 1);
        chk("break valid", vcyc - v0, 0);
        chk("break state", int'(dut.state_q), int'(IDLE));
        n0 = rx_n;
        send_frame(8'h12, 1'b1);
        repeat (20) tick();
        chk("after break count", rx_n - n0, 1);
        chk("after break data", int'(rx_mem[n0]), 8'h12);
        chk("after break frame_err", fe_cnt - f0, 1);
    endtask

    task automatic test_overrun();
        int o0, n0;
        o0 = ov_cnt; n0 = rx_n;
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (20) tick();
        chk("overrun valid held", int'(valid_o), 1);
        chk("overrun data kept", int'(data_o), 8'h11);
        chk("overrun pulses", ov_cnt - o0, 1);
        chk("overrun no transfer", rx_n - n0, 0);
        ready_i = 1'b1;
        tick();
        tick();
        chk("accept valid drops", int'(valid_o), 0);
        chk("accept data unchanged", int'(data_o), 8'h11);
        chk("accept transfer count", rx_n - n0, 1);
        chk("accept transfer data", int'(rx_mem[n0]), 8'h11);
    endtask

    task automatic test_reset_mid();
        int v0, n0;
        v0 = vcyc;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx_i = 1'b1;
        repeat (5) tick();
        rst_i = 1'b1;
        tick();
        chk("midrst data_o", int'(data_o), 0);
        chk("midrst valid_o", int'(valid_o), 0);
        chk("midrst state", int'(dut.state_q), int'(IDLE));
        tick();
        rst_i = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        repeat (20) tick();
        chk("midrst no valid", vcyc - v0, 0);
        n0 = rx_n;
        send_frame(8'h5A, 1'b1);
        repeat (20) tick();
        chk("midrst next count", rx_n - n0, 1);
        chk("midrst next data", int'(rx_mem[n0]), 8'h5A);
    endtask

    task automatic test_back_to_back();
        int f0, o0, n0;
        f0 = fe_cnt; o0 = ov_cnt; n0 = rx_n;
        for (int b = 0; b < 256; b++) send_frame(b[7:0], 1'b1);
        repeat (30) tick();
        chk("b2b count", rx_n - n0, 256);
        for (int b = 0; b < 256; b++) begin
            if (n0 + b < rx_n) chk("b2b byte", int'(rx_mem[(n0 + b) % 1024]), b);
        end
        chk("b2b frame_err", fe_cnt - f0, 0);
        chk("b2b overrun", ov_cnt - o0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
